// File: rtl/four_12_12_st3_mem_ctrl_pkg.sv
// Shared constants, FSM state type and RAM-control bundles for the stage-3 memory bank.
package four_12_12_st3_mem_ctrl_pkg;

   localparam int unsigned N_IN       = 12;
   localparam int unsigned N_OUT      = 12;
   localparam int unsigned TAP_W      = N_OUT * 32;
   localparam int unsigned DATA_DEPTH = 512;
   localparam int unsigned FRAMES     = DATA_DEPTH / N_IN;
   // The ring only uses whole frames; the tail of the data RAM (504..511) is never addressed.
   localparam int unsigned RING_WORDS = FRAMES * N_IN;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StBias
   } state_e;

   typedef struct packed {
      logic             en;
      logic             wr;
      logic [4:0]       addr;
      logic [TAP_W-1:0] wr_data;
   } tap_int_384_5;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wr_data;
   } bias_int_32_4;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wr_data;
   } data_int_32_9;

endpackage

// File: rtl/four_12_12_st3_data_ring.sv
// Frame ring bookkeeping for the data RAM: write pointer, read base, partial-frame count and
// the number of complete frames held.
module four_12_12_st3_data_ring
   import four_12_12_st3_mem_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_accept,
   input  logic       pass_done,
   output logic [8:0] wr_ptr,
   output logic [8:0] rd_base,
   output logic [5:0] frames_avail,
   output logic       has_room,
   output logic       has_frame
);

   localparam logic [8:0] PtrLast  = 9'(RING_WORDS - 1);
   localparam logic [8:0] BaseLast = 9'(RING_WORDS - N_IN);
   localparam logic [3:0] WordLast = 4'(N_IN - 1);

   logic [8:0] wr_ptr_q, wr_ptr_d;
   logic [8:0] rd_base_q, rd_base_d;
   logic [3:0] word_cnt_q, word_cnt_d;
   logic [5:0] frames_q, frames_d;
   logic       frame_done;

   assign frame_done = wr_accept && (word_cnt_q == WordLast);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_base_d  = rd_base_q;
      word_cnt_d = word_cnt_q;
      frames_d   = frames_q;
      if (wr_accept) begin
         wr_ptr_d   = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 9'd1;
         word_cnt_d = frame_done ? '0 : word_cnt_q + 4'd1;
      end
      if (pass_done) begin
         rd_base_d = (rd_base_q == BaseLast) ? '0 : rd_base_q + 9'(N_IN);
      end
      // A frame landing on the done cycle cancels the consumed one.
      if (frame_done && !pass_done) begin
         frames_d = frames_q + 6'd1;
      end else if (pass_done && !frame_done) begin
         frames_d = frames_q - 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_base_q  <= '0;
         word_cnt_q <= '0;
         frames_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_base_q  <= rd_base_d;
         word_cnt_q <= word_cnt_d;
         frames_q   <= frames_d;
      end
   end

   assign wr_ptr       = wr_ptr_q;
   assign rd_base      = rd_base_q;
   assign frames_avail = frames_q;
   assign has_room     = (frames_q < 6'(FRAMES));
   assign has_frame    = (frames_q != '0);

endmodule

// File: rtl/four_12_12_st3_mem_ctrl.sv
// Stage-3 memory controller: sequences one inference pass over the tap/data/bias RAMs and
// arbitrates their single ports between the pass, the data loader and the config loader.
module four_12_12_st3_mem_ctrl
   import four_12_12_st3_mem_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             dl_valid,
   output logic             dl_ready,
   input  logic [31:0]      dl_data,
   input  logic             cl_valid,
   output logic             cl_ready,
   input  logic             cl_sel,
   input  logic [4:0]       cl_addr,
   input  logic [TAP_W-1:0] cl_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [5:0]       frames_avail,
   output logic             tap_en,
   output logic             tap_wr,
   output logic [4:0]       tap_addr,
   output logic [TAP_W-1:0] tap_wr_data,
   output logic             bias_en,
   output logic             bias_wr,
   output logic [3:0]       bias_addr,
   output logic [31:0]      bias_wr_data,
   output logic             data_en,
   output logic             data_wr,
   output logic [8:0]       data_addr,
   output logic [31:0]      data_wr_data,
   output logic             mac_valid,
   output logic             mac_first,
   output logic             mac_last,
   output logic             bias_valid,
   output logic [3:0]       bias_idx
);

   localparam logic [3:0] LastIn   = 4'(N_IN - 1);
   localparam logic [3:0] LastOut  = 4'(N_OUT - 1);
   localparam logic [4:0] TapRows  = 5'(N_IN);
   localparam logic [4:0] BiasRows = 5'(N_OUT);

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         mac_valid_q, mac_first_q, mac_last_q, bias_valid_q;
   logic [3:0]   bias_idx_q;
   logic         read_issue, bias_issue, done_int, start_ok, dl_acc, cl_acc;
   logic [8:0]   wr_ptr, rd_base;
   logic         has_room, has_frame;
   tap_int_384_5 tap_c;
   bias_int_32_4 bias_c;
   data_int_32_9 data_c;

   four_12_12_st3_data_ring u_ring (
      .clk          (clk),
      .reset        (reset),
      .wr_accept    (dl_acc),
      .pass_done    (done),
      .wr_ptr       (wr_ptr),
      .rd_base      (rd_base),
      .frames_avail (frames_avail),
      .has_room     (has_room),
      .has_frame    (has_frame)
   );

   assign read_issue = (state_q == StRead) && !reset;
   assign bias_issue = (state_q == StBias) && !reset;
   assign done_int   = bias_valid_q && (bias_idx_q == LastOut);
   // done_int keeps start blocked on the last busy cycle even though the FSM is already idle.
   assign start_ok   = start && has_frame && (state_q == StIdle) && !done_int;
   assign dl_ready   = !reset && (state_q != StRead) && has_room;
   assign cl_ready   = !reset && (state_q == StIdle) && !(start && has_frame);
   assign dl_acc     = dl_valid && dl_ready;
   assign cl_acc     = cl_valid && cl_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: if (start_ok) begin
            state_d = StRead;
            cnt_d   = '0;
         end
         StRead: if (cnt_q == LastIn) begin
            state_d = StBias;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         StBias: if (cnt_q == LastOut) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mac_valid_q  <= 1'b0;
         mac_first_q  <= 1'b0;
         mac_last_q   <= 1'b0;
         bias_valid_q <= 1'b0;
         bias_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mac_valid_q  <= read_issue;
         mac_first_q  <= read_issue && (cnt_q == '0);
         mac_last_q   <= read_issue && (cnt_q == LastIn);
         bias_valid_q <= bias_issue;
         bias_idx_q   <= bias_issue ? cnt_q : '0;
      end
   end

   // Loaders are locked out of whichever RAM the pass currently owns, so the ports never collide.
   always_comb begin
      tap_c  = '0;
      bias_c = '0;
      data_c = '0;
      if (read_issue) begin
         data_c.en   = 1'b1;
         data_c.addr = rd_base + 9'(cnt_q);
         tap_c.en    = 1'b1;
         tap_c.addr  = 5'(cnt_q);
      end else if (dl_acc) begin
         data_c.en      = 1'b1;
         data_c.wr      = 1'b1;
         data_c.addr    = wr_ptr;
         data_c.wr_data = dl_data;
      end
      if (bias_issue) begin
         bias_c.en   = 1'b1;
         bias_c.addr = cnt_q;
      end
      if (cl_acc && !cl_sel && (cl_addr < TapRows)) begin
         tap_c.en      = 1'b1;
         tap_c.wr      = 1'b1;
         tap_c.addr    = cl_addr;
         tap_c.wr_data = cl_data;
      end
      if (cl_acc && cl_sel && (cl_addr < BiasRows)) begin
         bias_c.en      = 1'b1;
         bias_c.wr      = 1'b1;
         bias_c.addr    = cl_addr[3:0];
         bias_c.wr_data = cl_data[31:0];
      end
   end

   assign tap_en       = tap_c.en;
   assign tap_wr       = tap_c.wr;
   assign tap_addr     = tap_c.addr;
   assign tap_wr_data  = tap_c.wr_data;
   assign bias_en      = bias_c.en;
   assign bias_wr      = bias_c.wr;
   assign bias_addr    = bias_c.addr;
   assign bias_wr_data = bias_c.wr_data;
   assign data_en      = data_c.en;
   assign data_wr      = data_c.wr;
   assign data_addr    = data_c.addr;
   assign data_wr_data = data_c.wr_data;

   assign mac_valid  = mac_valid_q && !reset;
   assign mac_first  = mac_first_q && !reset;
   assign mac_last   = mac_last_q && !reset;
   assign bias_valid = bias_valid_q && !reset;
   assign bias_idx   = bias_idx_q;
   assign done       = done_int && !reset;
   assign busy       = !reset && ((state_q != StIdle) || done_int);

endmodule

// File: doc/four_12_12_st3_mem_ctrl.md
Name: four_12_12_st3_mem_ctrl

Overview:
- Sequencer and port arbiter for the stage-3 memory bank of the four_12_12 network: tap RAM (384-bit rows, 5-bit address), bias RAM (32-bit, 4-bit address) and data RAM (32-bit, 9-bit address).
- Manages the data RAM as a ring of input frames and loads tap/bias rows from the configuration loader.
- On request, runs one inference pass: streams N_IN (data word, tap row) pairs, then N_OUT biases, to the stage-3 MAC array.
- All RAMs are single-port with 1-cycle read latency.

Parameters:
- N_IN, 12, input words per frame and tap rows per pass.
- N_OUT, 12, outputs per pass and bias entries.
- TAP_W, 384, tap row width (N_OUT x 32).
- DATA_DEPTH, 512, data RAM depth in words.
- FRAMES, DATA_DEPTH/N_IN (=42, integer division), ring capacity in frames.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dl_valid / dl_ready  in/out  1/1  data-load handshake
- dl_data  in  32  input sample word
- cl_valid / cl_ready  in/out  1/1  config-load handshake
- cl_sel  in  1  0 = tap, 1 = bias
- cl_addr  in  5  row index
- cl_data  in  384  row data (bias uses [31:0])
- start  in  1  level request for a pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- frames_avail  out  6  count of complete frames held
- tap_en, tap_wr  out  1 each  tap RAM enable / write
- tap_addr  out  5  tap RAM address
- tap_wr_data  out  384  tap RAM write data
- bias_en, bias_wr  out  1 each  bias RAM enable / write
- bias_addr  out  4  bias RAM address
- bias_wr_data  out  32  bias RAM write data
- data_en, data_wr  out  1 each  data RAM enable / write
- data_addr  out  9  data RAM address
- data_wr_data  out  32  data RAM write data
- mac_valid, mac_first, mac_last  out  1 each  qualifiers for tap_rd_data/data_rd_data this cycle
- bias_valid  out  1  bias_rd_data valid this cycle
- bias_idx  out  4  output index of the valid bias

Behaviour:
- Reset: state IDLE. wr_ptr, rd_base, word_cnt, frames_avail = 0. All enables, valids, busy and done = 0. Ready outputs = 0 while reset is high.
- States and transitions:
  - IDLE -> READ when start=1 and frames_avail>0.
  - READ lasts N_IN cycles; index i = 0..N_IN-1. Each cycle: data_en=1, data_addr = rd_base+i; tap_en=1, tap_addr = i.
  - READ -> BIAS. BIAS lasts N_OUT cycles; o = 0..N_OUT-1. Each cycle: bias_en=1, bias_addr = o.
  - BIAS -> IDLE.
- Read-side outputs are the issue strobes delayed by 1 cycle:
  - mac_valid = READ issue delayed 1; mac_first with i=0, mac_last with i=N_IN-1.
  - bias_valid and bias_idx = BIAS issue delayed 1.
- done pulses together with the last bias_valid (o=N_OUT-1). On that cycle:
  - frames_avail decrements.
  - rd_base += N_IN, wrapping to 0 when it reaches FRAMES*N_IN (504).
- busy = 1 from the first READ cycle through the done cycle.
- Data load:
  - dl_ready = (state != READ) && (frames_avail < FRAMES).
  - On accept: data_wr=1 at wr_ptr; wr_ptr increments with the same wrap at 504; word_cnt increments.
  - When word_cnt reaches N_IN it clears and frames_avail increments.
  - If a frame completes in the same cycle as done, frames_avail is unchanged.
- Config load:
  - cl_ready = (state == IDLE) && !(start && frames_avail > 0). A starting pass wins over a config write.
  - On accept: tap or bias write at cl_addr.
  - Out-of-range addresses (tap >= N_IN, bias >= N_OUT) are accepted and dropped; no RAM enable.
- RAM ownership:
  - READ owns the data and tap RAMs; BIAS owns the bias RAM.
  - A data write during BIAS is legal; ports never collide.
  - A write strobe is never asserted in the same cycle as a read on the same RAM.
- start is ignored while busy or while frames_avail == 0.
- Reset mid-pass: immediate IDLE; pending valids and done are suppressed; the ring is emptied.

Decomposition:
- Shared package holds:
  - constants N_IN, N_OUT, TAP_W, DATA_DEPTH, FRAMES;
  - a state enum (IDLE, READ, BIAS);
  - the existing tap_int_384_5, bias_int_32_4 and data_int_32_9 RAM-control types, so the outputs map directly onto the memory-wrapper ports.
- One sub-module, four_12_12_st3_data_ring, owns wr_ptr, rd_base, word_cnt, frames_avail and the wrap/full logic.
- The top level keeps the FSM, config arbitration and the 1-cycle valid pipeline.

Test Plan:
- Reset, then write 12 words 0x100..0x10B -> data RAM addresses 0..11; frames_avail=1; dl_ready stays 1.
- Load tap rows 0..11 and biases 0..11, then hold start=1 -> 12 mac_valid cycles at addresses 0..11 with first/last flags, then bias_idx 0..11; done on cycle 25 after start; frames_avail=0; start then ignored.
- Fill 42 frames (504 words) -> dl_ready=0; one pass -> dl_ready returns 1 after done; next word goes to address 0 (wrap); rd_base advances to 12.
- Drive dl_valid throughout a pass -> no data write during the 12 READ cycles; writes resume in BIAS; frame completes on the done cycle with frames_avail unchanged.
- Assert start and cl_valid together in IDLE with a frame present -> pass starts, cl_ready=0; cl_addr=13 with cl_sel=0 -> accepted, no tap_en.
- Assert reset at READ cycle 5 -> next cycle is IDLE; no further mac_valid; no done; frames_avail=0.
